fir_ntap_pipe: RTL and testbench
================================

Name: fir_ntap_pipe

Overview:
- Parametrised N-tap moving-sum FIR: sums the TAPS most recent accepted samples through a fully pipelined, registered adder tree.
- Adds a valid handshake, a warm-up gate, a synchronous flush and an optional divide-by-TAPS averaging mode.
- Sits in the same sample datapath as the 4-tap adder blocks and replaces them when tap count or throughput requirements grow.

Parameters:
- W, 16, input sample width (signed two's complement), W >= 4.
- TAPS, 8, number of taps; power of two, 2..64.
- LG, $clog2(TAPS), derived localparam, not user-overridable; equals tree depth.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- in_valid  in  1  sample qualifier; a is accepted on a rising clk edge where in_valid=1.
- a  in  W  signed input sample.
- avg_mode  in  1  sampled together with a: 0 = output the sum, 1 = output the average (sum >>> LG).
- flush  in  1  synchronous clear of the delay line and fill counter.
- s  out  W+LG  signed result.
- out_valid  out  1  s holds a new result this cycle.

Behaviour:
- Reset (reset=0, asynchronous): all taps, tree registers, mode/valid pipeline, fill counter, s and out_valid go to 0 immediately. Operation resumes on the first clk edge after reset=1. Any in-flight results are lost and no out_valid is produced for them.
- Delay line: on an edge with in_valid=1, tap[0]<=a and tap[i]<=tap[i-1]. On an edge with in_valid=0 the taps hold.
- Fill counter: saturates at TAPS and increments on each accepted sample. "full" = counter reaches TAPS after the current accept.
- Tree: LG registered levels. Level j adds pairs from level j-1, and each level widens by 1 bit with sign extension. Level 0 is the tap registers. No truncation anywhere.
- Pipeline tag: tag = in_valid & full-after-accept, plus avg_mode. The tag advances one stage per edge, unconditionally. The tree also advances unconditionally.
- Latency: for a sample accepted at edge k, tree level LG is registered at edge k+LG and s/out_valid update at edge k+LG+1. For TAPS=8 this is 4 edges.
- Throughput: one result per cycle.
- Output stage:
  - If tag valid: s <= avg ? (sum >>> LG) sign-extended to W+LG : sum, and out_valid <= 1.
  - If tag not valid: s holds its value and out_valid <= 0.
- Average rounding: arithmetic shift, i.e. floor toward -inf.
- Warm-up: no out_valid until TAPS samples have been accepted since reset or flush.
- Flush:
  - On an edge with flush=1, taps and fill counter are cleared to 0 and tag bits at stage 0 are cleared.
  - Results already deeper in the pipeline still emerge.
  - If flush=1 and in_valid=1 on the same edge, flush wins and the sample is dropped.
- Mode: avg_mode travels with its sample, so changing it mid-stream affects only results whose triggering sample carried the new value.
- Overflow: impossible by construction. Range of s is [TAPS*-2^(W-1), TAPS*(2^(W-1)-1)].
- Gaps in in_valid: results reflect the last TAPS accepted samples regardless of the idle cycles between them.

Test Plan:
- TAPS=4, W=16, avg_mode=0: accept 1,2,3,4 back-to-back -> no out_valid for the first three; out_valid=1 with s=10 three edges after accepting 4. Then accept 5 -> s=14 on the next cycle.
- TAPS=4, avg_mode=1: accept -3,-3,-3,-2 -> s=-3 (sum -11 floored). Accept 4,4,4,5 -> s=4 (17>>2).
- TAPS=4 extremes: four 32767 -> s=131068. Four -32768 -> s=-131072. Both exact in 18 bits.
- TAPS=8 gapped stream: accept 1..8 with in_valid toggling 1,0,1,0,... -> single out_valid pulse, s=36, 4 edges after the 8th accept. No pulses on idle cycles.
- Flush: after the TAPS=4 stream 1..4 is full, assert flush together with in_valid (a=9) -> sample dropped. The next 3 accepts (7,7,7) produce no out_valid. The 4th accept (7) yields s=28.
- Async reset mid-stream: drop reset between edges while TAPS=8 results are in flight -> s=0 and out_valid=0 immediately, with no clk edge needed. After release, 8 new samples of 2 are required before s=16 appears.

Source files
------------

// File: rtl/fir_ntap_pipe_if.sv
// Sample-stream bundle for fir_ntap_pipe: qualified input sample with its
// mode/flush controls, and the qualified filter result.
interface fir_ntap_pipe_if #(
    parameter int W    = 16,
    parameter int TAPS = 8
);
    localparam int LG = $clog2(TAPS);

    logic                   in_valid;
    logic signed [W-1:0]    a;
    logic                   avg_mode;
    logic                   flush;
    logic signed [W+LG-1:0] s;
    logic                   out_valid;

    // Sample producer side
    modport master (
        output in_valid,
        output a,
        output avg_mode,
        output flush,
        input  s,
        input  out_valid
    );

    // Filter side
    modport slave (
        input  in_valid,
        input  a,
        input  avg_mode,
        input  flush,
        output s,
        output out_valid
    );
endinterface

// File: rtl/fir_ntap_pipe.sv
// N-tap moving-sum FIR with a fully registered binary adder tree.
// Sums the TAPS most recently accepted samples; optional divide-by-TAPS
// (arithmetic shift, floor toward -inf). Results appear LG+1 edges after
// the triggering sample, one per cycle. A result is only flagged once TAPS
// samples have been accepted since reset or flush. TAPS must be a power of
// two in 2..64 and W >= 4.
module fir_ntap_pipe #(
    parameter int W    = 16,
    parameter int TAPS = 8
) (
    input  logic           clk,
    input  logic           reset,
    fir_ntap_pipe_if.slave bus
);
    localparam int LG = $clog2(TAPS);
    localparam int SW = W + LG;
    localparam int CW = $clog2(TAPS + 1);

    // Tree is kept as a heap: node n has children 2n and 2n+1, the leaves
    // TAPS..2*TAPS-1 are the taps. The root (node 1) is the full sum. All
    // internal nodes are carried at the final width SW, which holds the
    // worst-case sum exactly, so nothing is ever truncated.
    logic signed [W-1:0]  r_tap  [TAPS];
    logic signed [SW-1:0] r_node [1:TAPS-1];
    logic signed [SW-1:0] w_node [1:2*TAPS-1];
    logic [CW-1:0]        r_fill;
    logic [LG:0]          r_tag_v;
    logic [LG:0]          r_tag_avg;
    logic signed [SW-1:0] r_s;
    logic                 r_out_valid;
    logic                 w_accept;
    logic                 w_full_after;

    // Accept qualification: flush overrides a simultaneous sample
    always_comb begin
        w_accept     = bus.in_valid & ~bus.flush;
        w_full_after = 1'b0;
        if (r_fill >= CW'(TAPS - 1)) begin
            w_full_after = 1'b1;
        end else begin
            w_full_after = 1'b0;
        end
    end

    // Heap view of the tree: internal registers plus sign-extended taps
    always_comb begin
        for (int n = 1; n < TAPS; n++) begin
            w_node[n] = r_node[n];
        end
        for (int i = 0; i < TAPS; i++) begin
            w_node[TAPS + i] = SW'(r_tap[i]);
        end
    end

    // Delay line and saturating fill counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_tap[i] <= {W{1'b0}};
            end
            r_fill <= {CW{1'b0}};
        end else if (bus.flush) begin
            for (int i = 0; i < TAPS; i++) begin
                r_tap[i] <= {W{1'b0}};
            end
            r_fill <= {CW{1'b0}};
        end else if (bus.in_valid) begin
            r_tap[0] <= bus.a;
            for (int i = 1; i < TAPS; i++) begin
                r_tap[i] <= r_tap[i-1];
            end
            if (r_fill != CW'(TAPS)) begin
                r_fill <= r_fill + CW'(1);
            end
        end
    end

    // Adder tree: every level registers the pairwise sums of the level below
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 1; n < TAPS; n++) begin
                r_node[n] <= {SW{1'b0}};
            end
        end else begin
            for (int n = 1; n < TAPS; n++) begin
                r_node[n] <= w_node[2*n] + w_node[2*n + 1];
            end
        end
    end

    // Valid/mode tag travels alongside the tree, one stage per edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag_v   <= {(LG+1){1'b0}};
            r_tag_avg <= {(LG+1){1'b0}};
        end else begin
            r_tag_v[0]      <= w_accept & w_full_after;
            r_tag_avg[0]    <= bus.avg_mode & ~bus.flush;
            r_tag_v[LG:1]   <= r_tag_v[LG-1:0];
            r_tag_avg[LG:1] <= r_tag_avg[LG-1:0];
        end
    end

    // Output register: load sum or floor-average when the tag is valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s         <= {SW{1'b0}};
            r_out_valid <= 1'b0;
        end else if (r_tag_v[LG]) begin
            r_out_valid <= 1'b1;
            if (r_tag_avg[LG]) begin
                r_s <= w_node[1] >>> LG;
            end else begin
                r_s <= w_node[1];
            end
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.s         = r_s;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_fir_ntap_pipe.sv
// Directed bench for fir_ntap_pipe: a TAPS=4 and a TAPS=8 instance share
// clock and reset; every edge is followed by a check of out_valid and s
// against hand-computed values.
module tb_fir_ntap_pipe;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    fir_ntap_pipe_if #(.W(16), .TAPS(4)) if4 ();
    fir_ntap_pipe_if #(.W(16), .TAPS(8)) if8 ();

    fir_ntap_pipe #(.W(16), .TAPS(4)) u_dut4 (.clk(clk), .reset(reset), .bus(if4));
    fir_ntap_pipe #(.W(16), .TAPS(8)) u_dut8 (.clk(clk), .reset(reset), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic step4(input string tag, input bit v, input int d, input bit m,
                         input bit f, input bit eov, input longint es);
        if4.in_valid = v;
        if4.a        = 16'(d);
        if4.avg_mode = m;
        if4.flush    = f;
        @(posedge clk);
        #1;
        chk({tag, ".ov4"}, longint'(if4.out_valid), longint'(eov));
        chk({tag, ".s4"}, longint'(if4.s), es);
        if4.in_valid = 1'b0;
        if4.flush    = 1'b0;
    endtask

    task automatic step8(input string tag, input bit v, input int d, input bit m,
                         input bit f, input bit eov, input longint es);
        if8.in_valid = v;
        if8.a        = 16'(d);
        if8.avg_mode = m;
        if8.flush    = f;
        @(posedge clk);
        #1;
        chk({tag, ".ov8"}, longint'(if8.out_valid), longint'(eov));
        chk({tag, ".s8"}, longint'(if8.s), es);
        if8.in_valid = 1'b0;
        if8.flush    = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        if4.in_valid = 1'b0; if4.a = 16'sd0; if4.avg_mode = 1'b0; if4.flush = 1'b0;
        if8.in_valid = 1'b0; if8.a = 16'sd0; if8.avg_mode = 1'b0; if8.flush = 1'b0;
        #1;
        chk("rst.ov4", longint'(if4.out_valid), 64'sd0);
        chk("rst.s4", longint'(if4.s), 64'sd0);
        chk("rst.ov8", longint'(if8.out_valid), 64'sd0);
        chk("rst.s8", longint'(if8.s), 64'sd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // TAPS=4 sum, back-to-back: 1..4 -> 10, then 5 -> 14 next cycle
        step4("sum", 1'b1, 1, 1'b0, 1'b0, 1'b0, 0);
        step4("sum", 1'b1, 2, 1'b0, 1'b0, 1'b0, 0);
        step4("sum", 1'b1, 3, 1'b0, 1'b0, 1'b0, 0);
        step4("sum", 1'b1, 4, 1'b0, 1'b0, 1'b0, 0);
        step4("sum", 1'b1, 5, 1'b0, 1'b0, 1'b0, 0);
        step4("sum", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        step4("sum", 1'b0, 0, 1'b0, 1'b0, 1'b1, 10);
        step4("sum", 1'b0, 0, 1'b0, 1'b0, 1'b1, 14);
        step4("sum", 1'b0, 0, 1'b0, 1'b0, 1'b0, 14);

        // Flush with simultaneous sample (dropped), then 7,7,7,7 -> 28
        step4("flush", 1'b1, 9, 1'b0, 1'b1, 1'b0, 14);
        step4("flush", 1'b1, 7, 1'b0, 1'b0, 1'b0, 14);
        step4("flush", 1'b1, 7, 1'b0, 1'b0, 1'b0, 14);
        step4("flush", 1'b1, 7, 1'b0, 1'b0, 1'b0, 14);
        step4("flush", 1'b1, 7, 1'b0, 1'b0, 1'b0, 14);
        step4("flush", 1'b0, 0, 1'b0, 1'b0, 1'b0, 14);
        step4("flush", 1'b0, 0, 1'b0, 1'b0, 1'b0, 14);
        step4("flush", 1'b0, 0, 1'b0, 1'b0, 1'b1, 28);

        // Result already in the tree survives a later flush: 1+7+7+7 = 22
        step4("deep", 1'b1, 1, 1'b0, 1'b0, 1'b0, 28);
        step4("deep", 1'b0, 0, 1'b0, 1'b1, 1'b0, 28);
        step4("deep", 1'b0, 0, 1'b0, 1'b0, 1'b0, 28);
        step4("deep", 1'b0, 0, 1'b0, 1'b0, 1'b1, 22);
        step4("deep", 1'b0, 0, 1'b0, 1'b0, 1'b0, 22);

        // Average mode: -3,-3,-3,-2 -> -11 floored /4 = -3
        step4("avg", 1'b1, -3, 1'b1, 1'b0, 1'b0, 22);
        step4("avg", 1'b1, -3, 1'b1, 1'b0, 1'b0, 22);
        step4("avg", 1'b1, -3, 1'b1, 1'b0, 1'b0, 22);
        step4("avg", 1'b1, -2, 1'b1, 1'b0, 1'b0, 22);
        step4("avg", 1'b0, 0, 1'b0, 1'b0, 1'b0, 22);
        step4("avg", 1'b0, 0, 1'b0, 1'b0, 1'b0, 22);
        step4("avg", 1'b0, 0, 1'b0, 1'b0, 1'b1, -3);

        // Mode travels per sample: sums -4,3,10,17; third sample is sum mode
        step4("mode", 1'b1, 4, 1'b1, 1'b0, 1'b0, -3);
        step4("mode", 1'b1, 4, 1'b1, 1'b0, 1'b0, -3);
        step4("mode", 1'b1, 4, 1'b0, 1'b0, 1'b0, -3);
        step4("mode", 1'b1, 5, 1'b1, 1'b0, 1'b1, -1);
        step4("mode", 1'b0, 0, 1'b0, 1'b0, 1'b1, 0);
        step4("mode", 1'b0, 0, 1'b0, 1'b0, 1'b1, 10);
        step4("mode", 1'b0, 0, 1'b0, 1'b0, 1'b1, 4);
        step4("mode", 1'b0, 0, 1'b0, 1'b0, 1'b0, 4);

        // Extremes: 4 x 32767 = 131068, 4 x -32768 = -131072
        step4("maxp", 1'b0, 0, 1'b0, 1'b1, 1'b0, 4);
        for (int i = 0; i < 4; i++) step4("maxp", 1'b1, 32767, 1'b0, 1'b0, 1'b0, 4);
        step4("maxp", 1'b0, 0, 1'b0, 1'b0, 1'b0, 4);
        step4("maxp", 1'b0, 0, 1'b0, 1'b0, 1'b0, 4);
        step4("maxp", 1'b0, 0, 1'b0, 1'b0, 1'b1, 131068);
        step4("maxn", 1'b0, 0, 1'b0, 1'b1, 1'b0, 131068);
        for (int i = 0; i < 4; i++) step4("maxn", 1'b1, -32768, 1'b0, 1'b0, 1'b0, 131068);
        step4("maxn", 1'b0, 0, 1'b0, 1'b0, 1'b0, 131068);
        step4("maxn", 1'b0, 0, 1'b0, 1'b0, 1'b0, 131068);
        step4("maxn", 1'b0, 0, 1'b0, 1'b0, 1'b1, -131072);

        // TAPS=8 gapped stream 1..8 -> single pulse of 36, 4 edges after the 8th
        for (int i = 1; i < 8; i++) begin
            step8("gap", 1'b1, i, 1'b0, 1'b0, 1'b0, 0);
            step8("gap", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        end
        step8("gap", 1'b1, 8, 1'b0, 1'b0, 1'b0, 0);
        step8("gap", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        step8("gap", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        step8("gap", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        step8("gap", 1'b0, 0, 1'b0, 1'b0, 1'b1, 36);
        step8("gap", 1'b0, 0, 1'b0, 1'b0, 1'b0, 36);

        // Results in flight: 2 replaces 1 -> 37 on the 5th edge
        for (int i = 0; i < 4; i++) step8("fly", 1'b1, 2, 1'b0, 1'b0, 1'b0, 36);
        step8("fly", 1'b1, 2, 1'b0, 1'b0, 1'b1, 37);

        // Asynchronous reset between edges clears outputs without a clock
        #2;
        reset = 1'b0;
        #1;
        chk("arst.ov8", longint'(if8.out_valid), 64'sd0);
        chk("arst.s8", longint'(if8.s), 64'sd0);
        chk("arst.s4", longint'(if4.s), 64'sd0);
        @(posedge clk);
        #1;
        chk("arst_hold.ov8", longint'(if8.out_valid), 64'sd0);
        chk("arst_hold.s8", longint'(if8.s), 64'sd0);
        @(negedge clk);
        reset = 1'b1;

        // After reset, eight fresh samples of 2 are needed before 16 appears
        for (int i = 0; i < 8; i++) step8("refill", 1'b1, 2, 1'b0, 1'b0, 1'b0, 0);
        step8("refill", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        step8("refill", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        step8("refill", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        step8("refill", 1'b0, 0, 1'b0, 1'b0, 1'b1, 16);
        step8("refill", 1'b0, 0, 1'b0, 1'b0, 1'b0, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
